// File: rtl/stream_minmax_tracker.sv
// Streaming unsigned min/max/count tracker for one frame of samples.
// The result is held on a valid/ready port until it is consumed.
module stream_minmax_tracker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] min_r;
    logic [DATA_W-1:0] max_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_c;
    logic [DATA_W:0]   min_diff_c;
    logic [DATA_W:0]   max_diff_c;
    logic [DATA_W-1:0] next_min_c;
    logic [DATA_W-1:0] next_max_c;
    logic [CNT_W-1:0]  next_cnt_c;

    // Borrow-out of the widened subtractions is the unsigned less-than result.
    always_comb begin
        accept_c   = in_valid && in_ready;
        min_diff_c = {1'b0, in_data} - {1'b0, min_r};
        max_diff_c = {1'b0, max_r} - {1'b0, in_data};
        next_min_c = min_r;
        next_max_c = max_r;
        next_cnt_c = cnt_r;
        if (state == IDLE) begin
            next_min_c = in_data;
            next_max_c = in_data;
            next_cnt_c = CNT_W'(1);
        end else begin
            if (min_diff_c[DATA_W]) next_min_c = in_data;
            if (max_diff_c[DATA_W]) next_max_c = in_data;
            if (cnt_r != CNT_MAX)   next_cnt_c = cnt_r + CNT_W'(1);
        end
    end

    // Frame FSM; out_* load only on entry to HOLD so partial results never show.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
            min_r     <= '0;
            max_r     <= '0;
            cnt_r     <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept_c) begin
                        min_r <= next_min_c;
                        max_r <= next_max_c;
                        cnt_r <= next_cnt_c;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_min   <= next_min_c;
                            out_max   <= next_max_c;
                            out_count <= next_cnt_c;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed plus randomized frames against two tracker instances (8-bit and
// 3-bit counters), compared with a plain min/max/count model of each frame.
module tb_stream_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready8, in_ready3;
    logic       out_valid8, out_valid3;
    logic [7:0] out_min8, out_min3, out_max8, out_max3;
    logic [7:0] out_count8;
    logic [2:0] out_count3;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] ret_min, ret_max, ret_cnt8;
    logic [2:0] ret_cnt3;

    always #5 clk = ~clk;

    stream_minmax_tracker #(.DATA_W(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_min(out_min8), .out_max(out_max8),
        .out_count(out_count8)
    );

    stream_minmax_tracker #(.DATA_W(8), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid3),
        .out_ready(out_ready), .out_min(out_min3), .out_max(out_max3),
        .out_count(out_count3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic vld, input logic rdy,
                             input logic [7:0] mn, input logic [7:0] mx,
                             input logic [7:0] c8, input logic [2:0] c3);
        check({tag, ".valid8"}, 32'(out_valid8), 32'(vld));
        check({tag, ".valid3"}, 32'(out_valid3), 32'(vld));
        check({tag, ".ready8"}, 32'(in_ready8), 32'(rdy));
        check({tag, ".ready3"}, 32'(in_ready3), 32'(rdy));
        check({tag, ".min8"}, 32'(out_min8), 32'(mn));
        check({tag, ".min3"}, 32'(out_min3), 32'(mn));
        check({tag, ".max8"}, 32'(out_max8), 32'(mx));
        check({tag, ".max3"}, 32'(out_max3), 32'(mx));
        check({tag, ".count8"}, 32'(out_count8), 32'(c8));
        check({tag, ".count3"}, 32'(out_count3), 32'(c3));
    endtask

    // Streams q as one frame with random idle gaps, then checks the result
    // through hold_cycles of backpressure and the handshake that follows.
    task automatic run_frame(input string tag, input int hold_cycles, input bit junk);
        int n = q.size();
        int emn = 255;
        int emx = 0;
        logic [7:0] e_min, e_max, e_c8;
        logic [2:0] e_c3;
        foreach (q[k]) begin
            if (int'(q[k]) < emn) emn = int'(q[k]);
            if (int'(q[k]) > emx) emx = int'(q[k]);
        end
        e_min = 8'(emn);
        e_max = 8'(emx);
        e_c8  = 8'((n < 255) ? n : 255);
        e_c3  = 3'((n < 7) ? n : 7);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                step();
                check_all({tag, ".gap"}, 1'b0, 1'b1, ret_min, ret_max, ret_cnt8, ret_cnt3);
            end
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == n - 1);
            if (i == n - 1 && hold_cycles == 0) out_ready = 1'b1;
            step();
            if (i != n - 1)
                check_all({tag, ".mid"}, 1'b0, 1'b1, ret_min, ret_max, ret_cnt8, ret_cnt3);
        end
        in_valid = junk;
        in_data  = 8'h99;
        in_last  = junk;
        check_all({tag, ".result"}, 1'b1, 1'b0, e_min, e_max, e_c8, e_c3);
        for (int h = 0; h < hold_cycles; h++) begin
            if (h == hold_cycles - 1) out_ready = 1'b1;
            step();
            if (h != hold_cycles - 1)
                check_all({tag, ".hold"}, 1'b1, 1'b0, e_min, e_max, e_c8, e_c3);
        end
        if (hold_cycles == 0) step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check_all({tag, ".after"}, 1'b0, 1'b1, e_min, e_max, e_c8, e_c3);
        ret_min  = e_min;
        ret_max  = e_max;
        ret_cnt8 = e_c8;
        ret_cnt3 = e_c3;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        ret_min = 8'h00; ret_max = 8'h00; ret_cnt8 = 8'h00; ret_cnt3 = 3'h0;
        step();
        step();
        check_all("reset", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'h0);
        rst_n = 1'b1;
        step();
        check_all("post_reset", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'h0);

        q = '{8'h37, 8'h05, 8'hF0, 8'h80};
        run_frame("basic", 0, 1'b0);

        q = '{8'h00};
        run_frame("single", 0, 1'b0);

        q = '{8'hFF, 8'h00, 8'h7F};
        run_frame("bounds", 0, 1'b0);

        q = '{8'h10, 8'h20};
        run_frame("backpressure", 6, 1'b1);

        // Abandoned frame: reset discards it and clears the outputs.
        in_valid = 1'b1; in_data = 8'h40; in_last = 1'b0;
        step();
        in_data = 8'h41;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_all("mid_reset", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 3'h0);
        ret_min = 8'h00; ret_max = 8'h00; ret_cnt8 = 8'h00; ret_cnt3 = 3'h0;

        q = '{8'h33};
        run_frame("after_reset", 0, 1'b0);

        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'hAA);
        run_frame("ties_sat", 1, 1'b0);

        for (int f = 0; f < 10; f++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) q.push_back(8'($urandom));
            run_frame("random", int'($urandom_range(0, 3)), 1'($urandom));
        end

        q = {};
        for (int i = 0; i < 300; i++) q.push_back(8'($urandom_range(1, 254)));
        run_frame("long_sat", 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
